// File: rtl/memory_mapped_io_controller.sv
// Memory-mapped I/O block for the LC-3 core: debounced accept capture into
// ISR/IDR, display status/data registers and a multiplexed hex display scanner.
module memory_mapped_io_controller #(
   parameter int          DATA_WIDTH             = 16,
   parameter int          DISPLAY_DIGITS         = 4,
   parameter int          DEBOUNCE_CYCLES        = 1000000,
   parameter int          REFRESH_CYCLES         = 100000,
   parameter logic [15:0] INPUT_STATUS_ADDRESS   = 16'hFE00,
   parameter logic [15:0] INPUT_DATA_ADDRESS     = 16'hFE02,
   parameter logic [15:0] DISPLAY_STATUS_ADDRESS = 16'hFE04,
   parameter logic [15:0] DISPLAY_DATA_ADDRESS   = 16'hFE06
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [15:0]               address,
   input  logic                      write_enable,
   input  logic                      read_enable,
   input  logic [DATA_WIDTH-1:0]     write_data,
   output logic [DATA_WIDTH-1:0]     read_data,
   input  logic [DATA_WIDTH-1:0]     switch,
   input  logic                      accept,
   output logic                      interrupt_request,
   output logic [6:0]                segments,
   output logic [DISPLAY_DIGITS-1:0] annodes
);

   localparam int DBC_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int REF_W = $clog2(REFRESH_CYCLES + 1);
   localparam int IDX_W = (DISPLAY_DIGITS > 1) ? $clog2(DISPLAY_DIGITS) : 1;

   logic                  accept_meta;
   logic                  accept_sync;
   logic                  accept_debounced;
   logic [DBC_W-1:0]      debounce_count;
   logic                  debounce_done;
   logic                  capture;

   logic [DATA_WIDTH-1:0] input_data;
   logic                  input_ready;
   logic                  overrun;
   logic                  interrupt_enable;
   logic                  display_blank;
   logic [DATA_WIDTH-1:0] display_data;

   logic                  sel_isr, sel_idr, sel_dsr, sel_ddr;
   logic                  idr_read;
   logic [DATA_WIDTH-1:0] read_value;

   logic [REF_W-1:0]      refresh_count;
   logic [IDX_W-1:0]      digit_index;
   logic [3:0]            digit_nibble;
   logic [DISPLAY_DIGITS-1:0] anode_pattern;

   function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
      logic [6:0] glyph;
      case (nibble)
         4'h0: glyph = 7'b0000001;
         4'h1: glyph = 7'b1001111;
         4'h2: glyph = 7'b0010010;
         4'h3: glyph = 7'b0000110;
         4'h4: glyph = 7'b1001100;
         4'h5: glyph = 7'b0100100;
         4'h6: glyph = 7'b0100000;
         4'h7: glyph = 7'b0001111;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0000100;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b1100000;
         4'hC: glyph = 7'b0110001;
         4'hD: glyph = 7'b1000010;
         4'hE: glyph = 7'b0110000;
         default: glyph = 7'b0111000;
      endcase
      return glyph;
   endfunction

   // The debounced level flips on the edge where the counter has seen
   // DEBOUNCE_CYCLES consecutive disagreeing samples; a rising flip is a capture.
   assign debounce_done = (debounce_count == DBC_W'(DEBOUNCE_CYCLES - 1));
   assign capture       = (accept_sync != accept_debounced) && debounce_done && accept_sync;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         accept_meta      <= 1'b0;
         accept_sync      <= 1'b0;
         accept_debounced <= 1'b0;
         debounce_count   <= '0;
      end else begin
         accept_meta <= accept;
         accept_sync <= accept_meta;
         if (accept_sync == accept_debounced) begin
            debounce_count <= '0;
         end else if (debounce_done) begin
            accept_debounced <= accept_sync;
            debounce_count   <= '0;
         end else begin
            debounce_count <= debounce_count + 1'b1;
         end
      end
   end

   assign sel_isr  = (address == INPUT_STATUS_ADDRESS);
   assign sel_idr  = (address == INPUT_DATA_ADDRESS);
   assign sel_dsr  = (address == DISPLAY_STATUS_ADDRESS);
   assign sel_ddr  = (address == DISPLAY_DATA_ADDRESS);
   assign idr_read = read_enable && sel_idr;

   always_comb begin
      read_value = '0;
      if (sel_isr) begin
         read_value[DATA_WIDTH-1] = input_ready;
         read_value[DATA_WIDTH-2] = overrun;
         read_value[DATA_WIDTH-3] = interrupt_enable;
      end else if (sel_idr) begin
         read_value = input_data;
      end else if (sel_dsr) begin
         read_value[DATA_WIDTH-1] = 1'b1;
         read_value[0]            = display_blank;
      end else if (sel_ddr) begin
         read_value = display_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         read_data         <= '0;
         input_data        <= '0;
         input_ready       <= 1'b0;
         overrun           <= 1'b0;
         interrupt_enable  <= 1'b0;
         display_blank     <= 1'b0;
         display_data      <= '0;
         interrupt_request <= 1'b0;
      end else begin
         if (read_enable) begin
            read_data <= read_value;
         end
         interrupt_request <= input_ready & interrupt_enable;
         // A capture coinciding with the IDR read refills the now-empty register.
         if (capture) begin
            if (!input_ready || idr_read) begin
               input_data  <= switch;
               input_ready <= 1'b1;
               overrun     <= 1'b0;
            end else begin
               overrun <= 1'b1;
            end
         end else if (idr_read) begin
            input_ready <= 1'b0;
            overrun     <= 1'b0;
         end
         if (write_enable && sel_isr) begin
            interrupt_enable <= write_data[DATA_WIDTH-3];
         end
         if (write_enable && sel_dsr) begin
            display_blank <= write_data[0];
         end
         if (write_enable && sel_ddr) begin
            display_data <= write_data;
         end
      end
   end

   always_comb begin
      digit_nibble  = 4'h0;
      anode_pattern = '1;
      for (int d = 0; d < DISPLAY_DIGITS; d++) begin
         if (digit_index == IDX_W'(d)) begin
            digit_nibble     = display_data[4*d +: 4];
            anode_pattern[d] = 1'b0;
         end
      end
   end

   // segments and annodes are registered together so digits never glitch.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         refresh_count <= '0;
         digit_index   <= '0;
         segments      <= 7'b0000001;
         annodes       <= ~DISPLAY_DIGITS'(1);
      end else begin
         if (refresh_count == REF_W'(REFRESH_CYCLES - 1)) begin
            refresh_count <= '0;
            if (digit_index == IDX_W'(DISPLAY_DIGITS - 1)) begin
               digit_index <= '0;
            end else begin
               digit_index <= digit_index + 1'b1;
            end
         end else begin
            refresh_count <= refresh_count + 1'b1;
         end
         segments <= hex_glyph(digit_nibble);
         annodes  <= display_blank ? '1 : anode_pattern;
      end
   end

endmodule

// File: tb/tb_memory_mapped_io_controller.sv
// Bench for memory_mapped_io_controller: directed steps plus random bus and
// accept traffic, every cycle checked against a behavioural register model.
module tb_memory_mapped_io_controller;

   localparam int DW  = 16;
   localparam int DIG = 4;
   localparam int DEB = 4;
   localparam int REF = 3;
   localparam logic [15:0] A_ISR = 16'hFE00;
   localparam logic [15:0] A_IDR = 16'hFE02;
   localparam logic [15:0] A_DSR = 16'hFE04;
   localparam logic [15:0] A_DDR = 16'hFE06;
   localparam logic [15:0] A_BAD = 16'hFE08;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic [15:0]    address = '0;
   logic           write_enable = 1'b0;
   logic           read_enable = 1'b0;
   logic [DW-1:0]  write_data = '0;
   logic [DW-1:0]  read_data;
   logic [DW-1:0]  switch = '0;
   logic           accept = 1'b0;
   logic           interrupt_request;
   logic [6:0]     segments;
   logic [DIG-1:0] annodes;

   always #5 clock = ~clock;

   memory_mapped_io_controller #(
      .DATA_WIDTH(DW), .DISPLAY_DIGITS(DIG),
      .DEBOUNCE_CYCLES(DEB), .REFRESH_CYCLES(REF)
   ) dut (
      .clock(clock), .reset(reset), .address(address),
      .write_enable(write_enable), .read_enable(read_enable),
      .write_data(write_data), .read_data(read_data),
      .switch(switch), .accept(accept),
      .interrupt_request(interrupt_request),
      .segments(segments), .annodes(annodes)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: register contents, accept sample history, edge count.
   logic           m_ready, m_ovr, m_ie, m_blank, m_deb, m_irq;
   logic [DW-1:0]  m_data, m_ddata, m_rd;
   logic [DIG-1:0] m_an;
   logic [6:0]     m_seg;
   int             m_edges;
   logic           raw_q[$];
   logic           win_q[$];

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;  default: return 7'b0111000;
      endcase
   endfunction

   function automatic logic [DW-1:0] model_read(input logic [15:0] a);
      case (a)
         A_ISR:   return {m_ready, m_ovr, m_ie, {(DW-3){1'b0}}};
         A_IDR:   return m_data;
         A_DSR:   return {1'b1, {(DW-2){1'b0}}, m_blank};
         A_DDR:   return m_ddata;
         default: return '0;
      endcase
   endfunction

   task automatic model_reset();
      m_ready = 0; m_ovr = 0; m_ie = 0; m_blank = 0; m_deb = 0; m_irq = 0;
      m_data = '0; m_ddata = '0; m_rd = '0;
      m_an = 4'b1110; m_seg = 7'b0000001; m_edges = 0;
      raw_q = {1'b0, 1'b0};
      win_q = {};
   endtask

   // One rising edge of the model, using inputs as they stand at that edge.
   task automatic model_step();
      int idx;
      int diff;
      logic s;
      logic cap;
      logic idr_rd;
      idx    = (m_edges / REF) % DIG;
      m_an   = m_blank ? '1 : ~(DIG'(1) << idx);
      m_seg  = glyph(m_ddata[4*idx +: 4]);
      if (read_enable) m_rd = model_read(address);
      m_irq  = m_ready & m_ie;
      idr_rd = read_enable && (address == A_IDR);
      // accept reaches the debouncer two edges late; it flips after DEB agreeing disagreements
      s = raw_q.pop_front();
      raw_q.push_back(accept);
      win_q.push_back(s);
      if (win_q.size() > DEB) void'(win_q.pop_front());
      cap = 1'b0;
      if (win_q.size() == DEB) begin
         diff = 0;
         foreach (win_q[i]) if (win_q[i] != m_deb) diff++;
         if (diff == DEB) begin
            m_deb = ~m_deb;
            cap   = m_deb;
         end
      end
      if (cap) begin
         if (!m_ready || idr_rd) begin
            m_data = switch; m_ready = 1; m_ovr = 0;
         end else begin
            m_ovr = 1;
         end
      end else if (idr_rd) begin
         m_ready = 0; m_ovr = 0;
      end
      if (write_enable && address == A_ISR) m_ie    = write_data[DW-3];
      if (write_enable && address == A_DSR) m_blank = write_data[0];
      if (write_enable && address == A_DDR) m_ddata = write_data;
      m_edges++;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check("read_data", 32'(read_data), 32'(m_rd));
      check("interrupt_request", 32'(interrupt_request), 32'(m_irq));
      check("annodes", 32'(annodes), 32'(m_an));
      check("segments", 32'(segments), 32'(m_seg));
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      check_outputs();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs();
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic read_reg(input logic [15:0] a);
      address = a; read_enable = 1'b1;
      tick();
      read_enable = 1'b0;
   endtask

   task automatic read_expect(input string tag, input logic [15:0] a, input logic [DW-1:0] v);
      read_reg(a);
      check(tag, 32'(read_data), 32'(v));
   endtask

   task automatic write_reg(input logic [15:0] a, input logic [DW-1:0] d);
      address = a; write_data = d; write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
   endtask

   task automatic press(input logic [DW-1:0] sw, input int high, input int low);
      switch = sw; accept = 1'b1;
      ticks(high);
      accept = 1'b0;
      ticks(low);
   endtask

   initial begin
      int hold;
      int op;
      logic [15:0] addrs [5];
      addrs = '{A_ISR, A_IDR, A_DSR, A_DDR, A_BAD};
      #1;
      apply_reset();
      check("reset_annodes", 32'(annodes), 32'h0000000E);
      check("reset_segments", 32'(segments), 32'h00000001);
      check("reset_read_data", 32'(read_data), 32'h0);
      check("reset_irq", 32'(interrupt_request), 32'h0);

      // single capture, then IDR read clears ready
      press(16'h1234, 10, 0);
      read_expect("isr_ready", A_ISR, 16'h8000);
      read_expect("idr_data", A_IDR, 16'h1234);
      read_expect("isr_cleared", A_ISR, 16'h0000);
      ticks(8);

      // two captures without a read -> overrun, first data kept
      press(16'hAAAA, 8, 8);
      press(16'h5555, 8, 8);
      read_expect("isr_overrun", A_ISR, 16'hC000);
      read_expect("idr_first", A_IDR, 16'hAAAA);
      read_expect("isr_after_ovr", A_ISR, 16'h0000);

      // bounces shorter than the debounce window are ignored
      press(16'h7777, 2, 1);
      press(16'h7777, 2, 8);
      read_expect("isr_bounce", A_ISR, 16'h0000);

      // interrupt path
      write_reg(A_ISR, 16'h2000);
      press(16'h0F0F, 8, 4);
      check("irq_high", 32'(interrupt_request), 32'h1);
      read_reg(A_IDR);
      check("irq_hold", 32'(interrupt_request), 32'h1);
      tick();
      check("irq_drop", 32'(interrupt_request), 32'h0);
      write_reg(A_ISR, 16'h0000);

      // unmapped address and read/write collision
      write_reg(A_BAD, 16'hFFFF);
      read_expect("unmapped", A_BAD, 16'h0000);
      write_reg(A_DDR, 16'h1357);
      address = A_DDR; write_data = 16'hBEEF; write_enable = 1'b1; read_enable = 1'b1;
      tick();
      write_enable = 1'b0; read_enable = 1'b0;
      check("rw_collision", 32'(read_data), 32'h1357);

      // scanner and blanking
      ticks(16);
      write_reg(A_DSR, 16'h0001);
      tick();
      check("blank_annodes", 32'(annodes), 32'h0000000F);
      read_expect("dsr_read", A_DSR, 16'h8001);
      write_reg(A_DSR, 16'h0000);
      ticks(6);

      // reset in the middle of a debounce
      accept = 1'b1;
      ticks(3);
      apply_reset();
      ticks(10);
      accept = 1'b0;
      ticks(8);

      // random traffic
      hold = 0;
      for (int i = 0; i < 700; i++) begin
         if (hold == 0) begin
            accept = 1'($urandom_range(0, 1));
            hold   = $urandom_range(1, 10);
         end
         hold--;
         switch       = DW'($urandom);
         write_data   = DW'($urandom);
         address      = addrs[$urandom_range(0, 4)];
         op           = $urandom_range(0, 9);
         read_enable  = (op < 5);
         write_enable = (op >= 7);
         tick();
      end
      read_enable = 1'b0; write_enable = 1'b0;
      ticks(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_mapped_io_controller.md
Name: memory_mapped_io_controller

Overview:
- Parametrised memory-mapped I/O block for the LC-3 core.
- Replaces the ad-hoc switch tristate buffer and the directly loaded seven-segment register with addressable registers:
  - input status (ISR), input data (IDR), display status (DSR), display data (DDR).
- Provides a debounced accept-button capture with ready/overrun handshake, an optional interrupt request, and a multiplexed multi-digit hex display scanner.
- Sits on the memory address/data path beside ram_generic; the core reads and writes it like memory.

Parameters:
- DATA_WIDTH, 16, bus/register width; must be >= 16.
- DISPLAY_DIGITS, 4, number of hex digits scanned; DISPLAY_DIGITS*4 <= DATA_WIDTH.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change on accept.
- REFRESH_CYCLES, 100000, clock cycles each digit is held before advancing.
- INPUT_STATUS_ADDRESS, 16'hFE00, ISR address.
- INPUT_DATA_ADDRESS, 16'hFE02, IDR address.
- DISPLAY_STATUS_ADDRESS, 16'hFE04, DSR address.
- DISPLAY_DATA_ADDRESS, 16'hFE06, DDR address.

Ports:
- clock  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  16  register address.
- write_enable  input  1  write strobe.
- read_enable  input  1  read strobe.
- write_data  input  DATA_WIDTH  write data.
- read_data  output  DATA_WIDTH  registered read data.
- switch  input  DATA_WIDTH  raw switch levels.
- accept  input  1  raw, asynchronous push-button.
- interrupt_request  output  1  registered (input_ready & interrupt_enable).
- segments  output  7  active-low {a,b,c,d,e,f,g}.
- annodes  output  DISPLAY_DIGITS  active-low one-hot digit select.

Behaviour:
- Reset (async, active-high):
  - Clears read_data, input_data, input_ready, overrun, interrupt_enable, display_blank, display_data, the debounce counter, refresh counter and digit index.
  - Clears the debounced accept and both synchroniser flops.
  - Outputs: interrupt_request=0, annodes = all ones except bit 0 = 0, segments=7'b0000001 (hex 0).
- Accept path:
  - accept passes through a 2-flop synchroniser.
  - The debounce counter resets whenever the synchronised level equals the debounced level; otherwise it increments.
  - On reaching DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - Capture event is the debounced rising edge. Latency from raw accept high is 2 + DEBOUNCE_CYCLES cycles.
  - Capture with input_ready=0: input_data<=switch, input_ready<=1.
  - Capture with input_ready=1: input_data unchanged, overrun<=1.
- Register map (any other address):
  - Reads return 0.
  - Writes ignored.
  - No side effects.
- ISR read value: {input_ready, overrun, interrupt_enable, zeros}, bits DATA_WIDTH-1, -2, -3.
- ISR write: only bit DATA_WIDTH-3 (interrupt_enable) is written; other bits ignored.
- IDR read:
  - Returns input_data.
  - Clears input_ready and overrun at the same edge.
  - IDR write ignored.
- IDR read and capture in the same cycle:
  - read_data returns the old input_data.
  - The capture wins: input_data<=switch, input_ready stays 1, overrun<=0.
- DSR:
  - Read value is {1, zeros, display_blank}; display is always ready.
  - Write updates display_blank from bit 0 only.
- DDR:
  - Write loads display_data. The new value appears on segments no later than the next digit advance.
  - Read returns display_data.
- Read latency: read_data updates one cycle after read_enable. It holds its value when read_enable=0.
- Simultaneous read and write to the same address: the write takes effect; read_data returns the pre-write value.
- interrupt_request: registered, so it goes high one cycle after input_ready & interrupt_enable becomes true.
- Display scanner:
  - The refresh counter counts 0..REFRESH_CYCLES-1 and wraps.
  - On wrap the digit index advances modulo DISPLAY_DIGITS, with wrap from DISPLAY_DIGITS-1 to 0.
  - annodes = ~(1 << index).
  - segments = active-low hex glyph of nibble display_data[4*index+3 : 4*index].
  - segments and annodes are registered together, so there is no glitching between digits.
  - display_blank=1 forces annodes to all ones; the counter keeps running.
- Reset asserted mid-debounce or mid-scan aborts immediately. A pending capture is lost.

Test Plan (DEBOUNCE_CYCLES=4, REFRESH_CYCLES=3, defaults otherwise):
- Reset deassert -> annodes=4'b1110, segments=7'b0000001, read_data=0, interrupt_request=0.
- switch=16'h1234, accept held high 10 cycles -> within 6 cycles, read ISR=16'h8000; read IDR=16'h1234; next ISR read=16'h0000.
- Two captures (16'hAAAA then 16'h5555) without an IDR read -> ISR=16'hC000, IDR=16'hAAAA; after the read, ISR=16'h0000.
- accept pulses high 2 cycles, low, high 2 cycles -> no capture; ISR stays 16'h0000.
- Write ISR=16'h2000, then capture -> interrupt_request=1 the cycle after input_ready rises; IDR read drops it one cycle after the read.
- Write DDR=16'hBEEF -> annodes cycles 1110,1101,1011,0111 every 3 cycles with segments F,E,E,B glyphs (0111000, 0110000, 0110000, 1100000). Write DSR=16'h0001 -> annodes=4'b1111.
